// File: rtl/counter_ext_stage_pkg.sv
// Shared encodings for the counter extension stage: counter modes and
// tracker FSM states.
package counter_ext_stage_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        COUNT_UP     = 2'b00,
        COUNT_DOWN   = 2'b01,
        COUNT_3_DOWN = 2'b10,
        CHARGE       = 2'b11
    } modo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

endpackage

// File: rtl/counter_step_check.sv
// Judges one counter step: compares the new nibble against the previous one
// under the applied mode and reports whether the nibble wrapped.
module counter_step_check
    import counter_ext_stage_pkg::*;
(
    input  logic [NIBBLE_W-1:0] q_p,
    input  logic [NIBBLE_W-1:0] q,
    input  modo_t               modo_p,
    input  logic                load,
    output logic                mismatch,
    output logic                wrap
);

    logic [NIBBLE_W-1:0] expect_q;

    always_comb begin
        expect_q = q_p;
        wrap     = 1'b0;
        mismatch = 1'b0;
        unique case (modo_p)
            COUNT_UP: begin
                expect_q = q_p + 4'd1;
                wrap     = (q_p == 4'hF);
                mismatch = load | (q != expect_q);
            end
            COUNT_DOWN: begin
                expect_q = q_p - 4'd1;
                wrap     = (q_p == 4'h0);
                mismatch = load | (q != expect_q);
            end
            COUNT_3_DOWN: begin
                expect_q = q_p - 4'd3;
                wrap     = (q_p < 4'd3);
                mismatch = load | (q != expect_q);
            end
            // The loaded nibble value is not visible here, so only LOAD is judged.
            CHARGE: begin
                mismatch = ~load;
            end
        endcase
    end

endmodule

// File: rtl/counter_ext_stage.sv
// Downstream stage of the 4-bit multi-mode counter: extends the nibble with
// an HI_W-bit upper count, checks each step, and presents it over VALID/READY.
module counter_ext_stage
    import counter_ext_stage_pkg::*;
#(
    parameter int unsigned HI_W     = 4,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       ENABLE,
    input  logic                       CNT_RESET,
    input  logic [1:0]                 MODO,
    input  logic [HI_W-1:0]            D_HI,
    input  logic [NIBBLE_W-1:0]        Q,
    input  logic                       LOAD,
    input  logic                       READY,
    input  logic                       CLR_ERR,
    output logic [HI_W+NIBBLE_W-1:0]   Q_EXT,
    output logic                       VALID,
    output logic                       OVF,
    output logic                       OVR,
    output logic                       ERR
);

    logic                en_p;
    logic                rst_p;
    modo_t               modo_p;
    logic [HI_W-1:0]     d_hi_p;
    logic [NIBBLE_W-1:0] q_p;
    logic                primed;

    state_t              state;
    state_t              state_next;
    logic [HI_W-1:0]     upper;
    logic [HI_W-1:0]     upper_next;
    logic [NIBBLE_W-1:0] nibble_next;

    logic                do_update;
    logic                ovf_hit;
    logic                err_set;
    logic                err_clr;
    logic                step_live;
    logic                mismatch;
    logic                wrap;
    logic                fault_hit;

    counter_step_check u_check (
        .q_p      (q_p),
        .q        (Q),
        .modo_p   (modo_p),
        .load     (LOAD),
        .mismatch (mismatch),
        .wrap     (wrap)
    );

    assign step_live = en_p & ~rst_p;
    // CLR_ERR in the same cycle suppresses a fresh fault.
    assign fault_hit = CHECK_EN & primed & mismatch & ~CLR_ERR;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        upper_next  = upper;
        nibble_next = Q;
        do_update   = 1'b0;
        ovf_hit     = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (step_live) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (!step_live) begin
                    state_next  = IDLE;
                    upper_next  = '0;
                    nibble_next = '0;
                    do_update   = 1'b1;
                end else if (fault_hit) begin
                    state_next = FAULT;
                    err_set    = 1'b1;
                end else begin
                    do_update = 1'b1;
                    unique case (modo_p)
                        COUNT_UP: begin
                            if (wrap) begin
                                upper_next = upper + HI_W'(1);
                                ovf_hit    = &upper;
                            end
                        end
                        COUNT_DOWN, COUNT_3_DOWN: begin
                            if (wrap) begin
                                upper_next = upper - HI_W'(1);
                                ovf_hit    = ~|upper;
                            end
                        end
                        CHARGE: begin
                            upper_next = d_hi_p;
                        end
                    endcase
                end
            end
            FAULT: begin
                if (CLR_ERR) begin
                    state_next = IDLE;
                    err_clr    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            en_p   <= 1'b0;
            rst_p  <= 1'b0;
            modo_p <= COUNT_UP;
            d_hi_p <= '0;
            q_p    <= '0;
            primed <= 1'b0;
            upper  <= '0;
            Q_EXT  <= '0;
            VALID  <= 1'b0;
            OVF    <= 1'b0;
            OVR    <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            en_p   <= ENABLE;
            rst_p  <= CNT_RESET;
            modo_p <= modo_t'(MODO);
            d_hi_p <= D_HI;
            q_p    <= Q;
            primed <= 1'b1;
            upper  <= upper_next;

            // A new update keeps VALID high even if the old word is accepted now.
            if (do_update) begin
                Q_EXT <= {upper_next, nibble_next};
                VALID <= 1'b1;
                if (VALID && !READY) begin
                    OVR <= 1'b1;
                end
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end

            if (ovf_hit) begin
                OVF <= 1'b1;
            end

            if (err_set) begin
                ERR <= 1'b1;
            end else if (err_clr) begin
                ERR <= 1'b0;
            end
        end
    end

endmodule
